fetch_align: RTL and testbench
==============================

Name: fetch_align

Overview:
- Halfword realigner between instruction fetch and the compressed decoder.
- Accepts word-aligned 32-bit fetch words and emits one instruction per handshake: either a 16-bit compressed parcel or a full 32-bit instruction.
- Handles 32-bit instructions that straddle two fetch words, and redirect targets on odd halfwords (pc[1]=1).
- Output bits [15:0] feed the decompressor input directly.

Parameters:
- RESETPC, 32'h0000_0000, pc value reported on inst_pc while nothing is valid after reset.

Ports:
- clk  input  1  core clock
- resetb  input  1  reset, asynchronous, active-low
- flush  input  1  pipeline redirect; discards all buffered state
- flush_pc  input  32  redirect target; bit0 is always 0, bit1 selects the halfword
- fetch_valid  input  1  fetch_data/fetch_pc valid
- fetch_ready  output  1  fetch word consumed this cycle
- fetch_data  input  32  fetched word, little-endian halfwords
- fetch_pc  input  32  address of fetch_data; bits [1:0]=0
- inst_valid  output  1  inst_* valid
- inst_ready  input  1  downstream accepts the instruction
- inst_data  output  32  instruction; compressed parcels are zero-extended to {16'h0, parcel}
- inst_pc  output  32  address of the instruction's first halfword
- inst_comp  output  1  inst_data[1:0] != 2'b11

Behaviour:
- Clock and reset: single clock clk; reset resetb is asynchronous, active-low.
- State registers:
  - res_valid, res_data[15:0], res_pc[31:0]: residue halfword.
  - skip: discard the lower half of the next fetch word.
- Reset values: res_valid=0, skip=0, res_data=0, res_pc=RESETPC. Outputs: inst_valid=0, inst_data=0, inst_pc=RESETPC, inst_comp=0, fetch_ready=0.
- Effective states:
  - EMPTY: !res_valid, !skip.
  - SKIP: skip.
  - RES_C: res_valid and res_data[1:0]!=11.
  - RES_W: res_valid and res_data[1:0]==11.
- EMPTY:
  - fetch_data[1:0]!=11: emit {16'h0, fetch_data[15:0]} at fetch_pc. On handshake, load residue with fetch_data[31:16] and fetch_pc+2.
  - Otherwise: emit fetch_data at fetch_pc. On handshake, no residue.
  - inst_valid=fetch_valid; fetch_ready=fetch_valid&inst_ready.
- SKIP:
  - inst_valid=0; fetch_ready=fetch_valid.
  - On accept: residue<=fetch_data[31:16], res_pc<=fetch_pc+2, skip<=0.
  - Costs one bubble cycle.
- RES_C:
  - Emit {16'h0, res_data} at res_pc; inst_valid=1; fetch_ready=0.
  - On handshake: res_valid<=0, returning to EMPTY.
- RES_W:
  - Emit {fetch_data[15:0], res_data} at res_pc; inst_valid=fetch_valid; fetch_ready=fetch_valid&inst_ready.
  - On handshake: residue<=fetch_data[31:16], res_pc<=fetch_pc+2. A straddling instruction never loses the upper half.
- inst_comp is derived from inst_data[1:0].
- Flush has priority over everything in its cycle:
  - inst_valid=0, fetch_ready=0; any fetch word presented that cycle is dropped.
  - Next cycle: res_valid=0, skip=flush_pc[1].
- Latency: zero-cycle combinational fetch->inst path; the residue adds one cycle of storage only.
- fetch_ready depends combinationally on inst_ready.
- pc arithmetic is 32-bit and wraps modulo 2^32: fetch_pc=32'hFFFF_FFFC gives residue pc 32'hFFFF_FFFE.
- Stall: when inst_ready=0, outputs and state hold; upstream must hold fetch_data stable.
- Reset mid-operation clears residue and skip immediately (asynchronous).

Optional Feature:
- Macro: ALIGN_OUTREG_EN.
- Defined:
  - inst_* are driven from a one-entry output register with a two-entry skid buffer.
  - Latency is one cycle; full throughput is sustained under back-pressure.
  - fetch_ready no longer depends combinationally on inst_ready.
  - Flush invalidates both skid entries.
- Undefined: combinational output as described above.

Decomposition:
- Shared include "opcode.vh" gains constants HW_WORD=2'b11 (uncompressed marker) and state encodings ALIGN_EMPTY/ALIGN_SKIP/ALIGN_RESC/ALIGN_RESW.
- One sub-module, align_skid: two-entry valid/ready skid buffer, instantiated only under ALIGN_OUTREG_EN.

Test Plan:
- Aligned 32-bit: word 32'h00500093 @0 -> inst 32'h00500093 pc 0, comp=0, no residue.
- Two compressed: word 32'h00014501 @0 -> inst 16'h4501 pc 0, then 16'h0001 pc 2 with fetch_ready=0 during the second.
- Straddle: word 32'h00934505 @0, then 32'h12340050 @4 -> 16'h4505 pc 0, then 32'h00500093 pc 2, residue 16'h1234 pc 6.
- Odd redirect: flush with flush_pc=32'h102, word 32'h45010001 @0x100 -> one bubble, then inst 16'h4501 pc 0x102.
- Back-pressure plus flush: inst_ready=0 for 3 cycles in RES_W -> outputs stable; then flush with flush_pc=0x200 -> inst_valid=0, residue discarded, next word @0x200 emits from EMPTY.
- Wrap and reset: compressed low half @32'hFFFFFFFC -> residue pc 32'hFFFFFFFE; resetb low mid-stall -> all outputs reset values asynchronously.

Source files
------------

// File: rtl/fetch_align_pkg.sv
// fetch_align_pkg: shared constants, effective alignment states and parcel helpers for fetch_align.
package fetch_align_pkg;
  localparam logic [1:0] HW_WORD = 2'b11;
  typedef enum logic [1:0] {ALIGN_EMPTY, ALIGN_SKIP, ALIGN_RESC, ALIGN_RESW} align_state_e;
  function automatic logic is_comp(input logic [15:0] h);
    return h[1:0] != HW_WORD;
  endfunction
endpackage

// File: rtl/align_skid.sv
// align_skid: two-entry valid/ready skid buffer; in_ready is registered so upstream never sees out_ready combinationally.
module align_skid #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         resetb,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic [W-1:0] mem [2];
  logic wp, rp, push, pop;
  logic [1:0] cnt;
  assign in_ready  = cnt != 2'd2;
  assign out_valid = cnt != 2'd0;
  assign out_data  = mem[rp];
  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (push) wp <= !wp;
      if (pop) rp <= !rp;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_data;
endmodule

// File: rtl/fetch_align.sv
// fetch_align: halfword realigner from word fetch to one instruction per handshake; ALIGN_OUTREG_EN adds a registered skid output stage.
module fetch_align
  import fetch_align_pkg::*;
#(
  parameter logic [31:0] RESETPC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [31:0] fetch_data,
  input  logic [31:0] fetch_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        inst_comp
);
  logic        res_valid, skip, live, uses_fetch, c_valid, c_ready;
  logic [15:0] res_data;
  logic [31:0] res_pc, c_data, c_pc;
  align_state_e st;
  always_comb begin
    st = skip ? ALIGN_SKIP : !res_valid ? ALIGN_EMPTY : is_comp(res_data) ? ALIGN_RESC : ALIGN_RESW;
    live = resetb && !flush;
    uses_fetch = st == ALIGN_EMPTY || st == ALIGN_RESW;
    c_valid = live && (st == ALIGN_RESC || (uses_fetch && fetch_valid));
    c_data = st == ALIGN_RESC ? {16'h0, res_data} :
             st == ALIGN_RESW ? {fetch_data[15:0], res_data} :
             is_comp(fetch_data[15:0]) ? {16'h0, fetch_data[15:0]} : fetch_data;
    c_pc = st == ALIGN_EMPTY ? fetch_pc : res_pc;
    fetch_ready = live && fetch_valid && (st == ALIGN_SKIP || (uses_fetch && c_ready));
  end
  // Any consumed word leaves its upper half behind; it only counts as a residue
  // when it is the start of a new instruction rather than an already-emitted 32-bit one.
  always_ff @(posedge clk or negedge resetb)
    if (!resetb) begin
      res_valid <= 1'b0;
      skip      <= 1'b0;
      res_data  <= '0;
      res_pc    <= RESETPC;
    end else if (flush) begin
      res_valid <= 1'b0;
      skip      <= flush_pc[1];
      res_pc    <= flush_pc;
    end else if (fetch_ready) begin
      res_valid <= st != ALIGN_EMPTY || is_comp(fetch_data[15:0]);
      res_data  <= fetch_data[31:16];
      res_pc    <= fetch_pc + 32'd2;
      skip      <= 1'b0;
    end else if (c_valid && c_ready) begin
      res_valid <= 1'b0;
    end
`ifdef ALIGN_OUTREG_EN
  logic [63:0] q;
  logic        q_valid;
  align_skid #(.W(64)) u_skid (
    .clk(clk), .resetb(resetb), .flush(flush),
    .in_valid(c_valid), .in_ready(c_ready), .in_data({c_data, c_pc}),
    .out_valid(q_valid), .out_ready(inst_ready), .out_data(q)
  );
  always_comb begin
    inst_valid = q_valid;
    inst_data  = q_valid ? q[63:32] : '0;
    inst_pc    = q_valid ? q[31:0] : res_pc;
  end
`else
  assign c_ready = inst_ready;
  always_comb begin
    inst_valid = c_valid;
    inst_data  = c_valid ? c_data : '0;
    inst_pc    = c_valid ? c_pc : res_pc;
  end
`endif
  assign inst_comp = inst_valid && is_comp(inst_data[15:0]);
endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align: directed scenarios plus random instruction streams checked against a halfword-parsing reference.
module tb_fetch_align;
  logic clk = 1'b0, resetb = 1'b0, flush = 1'b0, fetch_valid = 1'b0, inst_ready = 1'b0;
  logic [31:0] flush_pc = '0, fetch_data = '0, fetch_pc = '0;
  logic fetch_ready, inst_valid, inst_comp;
  logic [31:0] inst_data, inst_pc;
  int vectors = 0, miscompares = 0;
  logic [15:0] mem [128];
  localparam logic [31:0] BASE = 32'h0000_1000;

  fetch_align #(.RESETPC(32'h0)) dut (
    .clk(clk), .resetb(resetb), .flush(flush), .flush_pc(flush_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data), .fetch_pc(fetch_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .inst_comp(inst_comp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
    vectors++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] fd, input logic [31:0] fp, input logic ir,
                       input logic fl, input logic [31:0] fpc);
    @(negedge clk);
    fetch_valid = fv; fetch_data = fd; fetch_pc = fp; inst_ready = ir; flush = fl; flush_pc = fpc;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] d, input logic [31:0] p,
                            input logic fr);
    check({tag, "/valid"}, inst_valid, v);
    if (v) begin
      check({tag, "/data"}, inst_data, d);
      check({tag, "/pc"}, inst_pc, p);
      check({tag, "/comp"}, inst_comp, d[1:0] != 2'b11);
    end
    check({tag, "/fetch_ready"}, fetch_ready, fr);
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    int i;
    i = int'((a - BASE) >> 1);
    return (i >= 0 && i < 127) ? {mem[i+1], mem[i]} : 32'h0;
  endfunction

  initial begin
    logic [63:0] exp_q [$];
    logic [63:0] e;
    logic [31:0] target, hp, fa;
    logic [15:0] h;
    logic fv;
    int cyc, i;
    // reset state
    #1;
    check("reset/valid", inst_valid, 1'b0);
    check("reset/data", inst_data, 32'h0);
    check("reset/pc", inst_pc, 32'h0);
    check("reset/comp", inst_comp, 1'b0);
    check("reset/fetch_ready", fetch_ready, 1'b0);
    @(negedge clk) resetb = 1'b1;
    // aligned 32-bit
    drive(1, 32'h00500093, 32'h0, 1, 0, 0);
    expect_out("aligned", 1, 32'h00500093, 32'h0, 1);
    drive(0, 32'h0, 32'h4, 1, 0, 0);
    expect_out("aligned/no_res", 0, 0, 0, 0);
    // two compressed, then straddle
    drive(1, 32'h00014501, 32'h0, 1, 0, 0);
    expect_out("comp_lo", 1, 32'h4501, 32'h0, 1);
    drive(1, 32'h00934505, 32'h0, 1, 0, 0);
    expect_out("comp_hi", 1, 32'h0001, 32'h2, 0);
    drive(1, 32'h00934505, 32'h0, 1, 0, 0);
    expect_out("strad_c", 1, 32'h4505, 32'h0, 1);
    drive(1, 32'h12340050, 32'h4, 1, 0, 0);
    expect_out("strad_w", 1, 32'h00500093, 32'h2, 1);
    drive(0, 32'h0, 32'h8, 1, 0, 0);
    expect_out("strad_res", 1, 32'h1234, 32'h6, 0);
    // odd redirect
    drive(1, 32'hdeadbeef, 32'h500, 1, 1, 32'h102);
    expect_out("odd/flush", 0, 0, 0, 0);
    drive(1, 32'h45010001, 32'h100, 1, 0, 0);
    expect_out("odd/bubble", 0, 0, 0, 1);
    drive(0, 32'h0, 32'h104, 1, 0, 0);
    expect_out("odd/inst", 1, 32'h4501, 32'h102, 0);
    // back-pressure in RES_W, then flush
    drive(1, 32'h00934505, 32'h300, 1, 0, 0);
    expect_out("bp/first", 1, 32'h4505, 32'h300, 1);
    repeat (3) begin
      drive(1, 32'h12340050, 32'h304, 0, 0, 0);
      expect_out("bp/stall", 1, 32'h00500093, 32'h302, 0);
    end
    drive(1, 32'h12340050, 32'h304, 1, 1, 32'h200);
    expect_out("bp/flush", 0, 0, 0, 0);
    drive(1, 32'h00500093, 32'h200, 1, 0, 0);
    expect_out("bp/after", 1, 32'h00500093, 32'h200, 1);
    // pc wrap, then asynchronous reset mid-stall
    drive(1, 32'h00014501, 32'hFFFF_FFFC, 1, 0, 0);
    expect_out("wrap/lo", 1, 32'h4501, 32'hFFFF_FFFC, 1);
    drive(1, 32'h00500093, 32'h0, 0, 0, 0);
    expect_out("wrap/hi", 1, 32'h0001, 32'hFFFF_FFFE, 0);
    #2 resetb = 1'b0;
    #1;
    check("areset/valid", inst_valid, 1'b0);
    check("areset/data", inst_data, 32'h0);
    check("areset/pc", inst_pc, 32'h0);
    check("areset/comp", inst_comp, 1'b0);
    check("areset/fetch_ready", fetch_ready, 1'b0);
    @(negedge clk) resetb = 1'b1;
    // random streams: expected instructions parsed straight from halfword memory
    for (int k = 0; k < 128; k++) begin
      mem[k] = 16'($urandom);
      if ($urandom_range(0, 1) == 1) mem[k][1:0] = 2'b11;
    end
    for (int seg = 0; seg < 6; seg++) begin
      target = BASE + 32'(2 * $urandom_range(0, 40));
      exp_q.delete();
      hp = target;
      repeat (30) begin
        i = int'((hp - BASE) >> 1);
        h = mem[i];
        if (h[1:0] != 2'b11) begin
          exp_q.push_back({16'h0, h, hp});
          hp += 2;
        end else begin
          exp_q.push_back({mem[i+1], h, hp});
          hp += 4;
        end
      end
      drive(1'($urandom), 32'($urandom), 32'h0, 1'($urandom), 1, target);
      check("rnd/flush_valid", inst_valid, 1'b0);
      check("rnd/flush_ready", fetch_ready, 1'b0);
      fa = target & ~32'h3;
      fv = 1'b0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 2000) begin
        @(negedge clk);
        flush = 1'b0;
        if (!fv) fv = $urandom_range(0, 3) != 0;
        fetch_valid = fv; fetch_pc = fa; fetch_data = word_at(fa);
        inst_ready = $urandom_range(0, 2) != 0;
        #1;
        if (inst_valid && inst_ready) begin
          e = exp_q.pop_front();
          check("rnd/inst", {inst_data, inst_pc}, e);
          check("rnd/comp", inst_comp, e[33:32] != 2'b11);
        end
        if (fetch_valid && fetch_ready) begin
          fa += 4;
          fv = 1'b0;
        end
        cyc++;
      end
      check("rnd/drained", 64'(exp_q.size()), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
